// File: rtl/adc_cmd_dispatcher_if.sv
// UART byte-stream bundle between the serial front end and the command dispatcher.
// A byte moves on either channel in every cycle where its valid and ready are both high.
// Valid, once raised, holds its data stable until that transfer, and ready may depend on valid.
interface adc_cmd_dispatcher_if;
    logic [7:0] RxData;
    logic       RxValid;
    logic       RxReady;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;

    modport slave (
        input  RxData, RxValid, TxReady,
        output RxReady, TxData, TxValid
    );

    modport master (
        output RxData, RxValid, TxReady,
        input  RxReady, TxData, TxValid
    );
endinterface

// File: rtl/adc_cmd_dispatcher.sv
// Turns UART command bytes into Cmd/NewCmd strobes for the ADC state machine and returns
// one reply byte per command. It also generates the auto-sleep and trigger wake-up pulses.
module adc_cmd_dispatcher #(
    parameter int RESP_TIMEOUT      = 1024,
    parameter int IDLE_SLEEP_CYCLES = 2**20,
    parameter int AUTO_SLEEP_EN     = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    adc_cmd_dispatcher_if.slave     uart,
    output logic [7:0]              Cmd,
    output logic                    NewCmd,
    input  logic [3:0]              AdcState,
    input  logic                    TriggerArm,
    output logic                    Sleep,
    output logic                    WakeUp,
    output logic [2:0]              dbg_state
);
    localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam int IW = (IDLE_SLEEP_CYCLES > 1) ? $clog2(IDLE_SLEEP_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(RESP_TIMEOUT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(IDLE_SLEEP_CYCLES - 1);

    localparam logic [3:0] ST_SAMPLING = 4'd8;
    localparam logic [3:0] ST_LOW_PWR  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_CHG = 3'd3,
        S_REPLY    = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      cmd_byte;
    logic [3:0]      snap;
    logic [TW-1:0]   tcnt;
    logic [IW-1:0]   icnt;
    logic            trig_q;
    logic            rx_fire;
    logic            is_cmd;
    logic            reply_load;
    logic [7:0]      reply_byte;
    logic [7:0]      hex_char;
    logic            idle_cond;

    assign rx_fire = uart.RxValid && uart.RxReady;

    always_comb begin
        is_cmd = 1'b0;
        case (cmd_byte)
            8'h4F, 8'h6F, 8'h43, 8'h4E, 8'h53, 8'h57: is_cmd = 1'b1;
            default:                                  is_cmd = 1'b0;
        endcase
    end

    assign hex_char = (AdcState < 4'd10) ? (8'h30 + {4'h0, AdcState})
                                         : (8'h37 + {4'h0, AdcState});

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; also picks the reply byte on every entry to REPLY
    always_comb begin
        state_next = state;
        reply_load = 1'b0;
        reply_byte = 8'h00;
        case (state)
            S_IDLE: begin
                if (rx_fire) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_cmd) begin
                    state_next = S_ISSUE;
                end else begin
                    state_next = S_REPLY;
                    reply_load = 1'b1;
                    reply_byte = (cmd_byte == 8'h3F) ? hex_char : 8'h3F;
                end
            end
            S_ISSUE: state_next = S_WAIT_CHG;
            S_WAIT_CHG: begin
                // A state change wins over a timeout landing in the same cycle
                if (AdcState != snap) begin
                    state_next = S_REPLY;
                    reply_load = 1'b1;
                    reply_byte = cmd_byte;
                end else if (tcnt == T_LAST) begin
                    state_next = S_REPLY;
                    reply_load = 1'b1;
                    reply_byte = 8'h21;
                end
            end
            S_REPLY: begin
                if (uart.TxReady) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        uart.RxReady = (state == S_IDLE) && !Reset;
        uart.TxValid = (state == S_REPLY);
        NewCmd       = (state == S_ISSUE);
        dbg_state    = state;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cmd_byte    <= 8'h00;
            Cmd         <= 8'h00;
            uart.TxData <= 8'h00;
            snap        <= 4'h0;
            tcnt        <= '0;
        end else begin
            if (rx_fire) cmd_byte <= uart.RxData;
            if (state == S_DECODE && is_cmd) Cmd <= cmd_byte;
            if (state == S_ISSUE) begin
                snap <= AdcState;
                tcnt <= '0;
            end else if (state == S_WAIT_CHG && tcnt != T_LAST) begin
                tcnt <= tcnt + 1'b1;
            end
            if (reply_load) uart.TxData <= reply_byte;
        end
    end

    // Sleep only ever comes from an IDLE cycle, so it can never coincide with ISSUE
    assign idle_cond = (AUTO_SLEEP_EN != 0) && (AdcState == ST_SAMPLING) &&
                       !TriggerArm && (state == S_IDLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            icnt   <= '0;
            Sleep  <= 1'b0;
            trig_q <= 1'b0;
            WakeUp <= 1'b0;
        end else begin
            Sleep <= 1'b0;
            if (!idle_cond) begin
                icnt <= '0;
            end else if (icnt == I_LAST) begin
                icnt  <= '0;
                Sleep <= 1'b1;
            end else begin
                icnt <= icnt + 1'b1;
            end
            trig_q <= TriggerArm;
            WakeUp <= TriggerArm && !trig_q && (AdcState == ST_LOW_PWR);
        end
    end
endmodule

// File: doc/adc_cmd_dispatcher.md
Name: adc_cmd_dispatcher

Overview:
Upstream neighbour of the ADC power/calibration state machine. Accepts command bytes from the UART receive path. Issues single-cycle Cmd/NewCmd strobes to the ADC state machine and returns one reply byte per command on the UART transmit path. Also generates the Sleep and WakeUp pulses, using an auto-sleep idle timer and trigger-arm edge detection.

Parameters:
RESP_TIMEOUT, 1024, cycles to wait for the ADC state to change after a command before replying "!"
IDLE_SLEEP_CYCLES, 2**20, consecutive idle cycles in DES_SAMPLING before a Sleep pulse
AUTO_SLEEP_EN, 1, 1 enables the idle timer; 0 holds Sleep low permanently

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
RxData  in  8  received command byte
RxValid  in  1  RxData valid
RxReady  out  1  dispatcher accepts byte (transfer when RxValid&&RxReady)
TxData  out  8  reply byte
TxValid  out  1  reply valid; held with TxData stable until TxReady
TxReady  in  1  UART TX accepts byte
Cmd  out  8  command byte to ADC state machine
NewCmd  out  1  one-cycle qualifier for Cmd
AdcState  in  4  current ADC state code (8=DES_SAMPLING, 10=LOW_PWR_IDLE)
TriggerArm  in  1  acquisition request from trigger logic, level
Sleep  out  1  one-cycle request to enter low-power idle
WakeUp  out  1  one-cycle request to leave low-power idle

Behaviour:
- Reset: state IDLE; RxReady=0, TxValid=0, TxData=0x00, Cmd=0x00, NewCmd=0, Sleep=0, WakeUp=0; idle and timeout counters cleared; TriggerArm edge register cleared. Reset mid-command aborts the command and drops any pending reply.
- States: IDLE, DECODE, ISSUE, WAIT_CHG, REPLY.
- IDLE: RxReady=1 (only state where it is 1). On transfer: latch byte -> DECODE. One command in flight at a time.
- DECODE (1 cycle):
  - byte in {"O","o","C","N","S","W"} -> ISSUE
  - byte == "?" -> REPLY with hex of AdcState: AdcState<10 ? 0x30+AdcState : 0x37+AdcState ("0".."9","A".."F")
  - any other byte -> REPLY with 0x3F ("?")
- ISSUE (1 cycle): NewCmd=1, Cmd=latched byte; snapshot AdcState; clear timeout counter -> WAIT_CHG. Cmd holds its last value afterwards and is only qualified by NewCmd.
- WAIT_CHG:
  - AdcState != snapshot -> REPLY with the command byte (ack).
  - Counter reaches RESP_TIMEOUT-1 with no change -> REPLY with 0x21 ("!"), e.g. "N" sent outside CALIBRATION.
  - A change on the same cycle as timeout counts as ack.
- REPLY: TxValid=1, TxData stable; on TxReady -> IDLE next cycle, TxValid=0. TxReady low for any duration is tolerated.
- Latency: byte accepted cycle t -> NewCmd at t+2; "?" reply TxValid at t+2.
- Idle timer:
  - Counts while AUTO_SLEEP_EN && AdcState==8 && TriggerArm==0 && dispatcher in IDLE.
  - Cleared on any cycle the condition fails.
  - On reaching IDLE_SLEEP_CYCLES-1: Sleep=1 for one cycle, counter cleared.
  - Sleep is never asserted in the same cycle as NewCmd.
- WakeUp: registered rising edge of TriggerArm while AdcState==10 -> WakeUp=1 one cycle after the edge. A rising edge in any other state is ignored, including one while AdcState==8, which only clears the idle timer.
- Counters saturate-free; widths are $clog2 of their parameter. No wrap-around is observable because each counter clears on terminal count.

Test Plan:
- Reset, then byte "O" with AdcState 0 changing to 1 three cycles after NewCmd -> NewCmd one cycle with Cmd=0x4F at accept+2; TxData=0x4F, TxValid held until TxReady.
- "N" with AdcState held at 4 -> NewCmd pulse, then after RESP_TIMEOUT cycles TxData=0x21; RxReady low throughout.
- "?" with AdcState=12 -> no NewCmd, TxData=0x43 ("C"); "?" with AdcState=8 -> TxData=0x38; byte "x" -> TxData=0x3F, no NewCmd.
- IDLE_SLEEP_CYCLES=16, AdcState=8, TriggerArm=0 -> Sleep pulse every 16 cycles. TriggerArm high at cycle 10 -> no Sleep; count restarts after TriggerArm falls.
- AdcState=10, TriggerArm 0->1 -> single WakeUp pulse. Same edge at AdcState=8 -> no WakeUp.
- Reset asserted during WAIT_CHG and during REPLY with TxReady=0 -> all outputs return to reset values the next cycle; next byte processed normally.
